mcp3002_sched: RTL and testbench

- Conversion scheduler for the MCP3002 SPI ADC transaction engine. The engine is the existing sclk/mosi/cs/miso datapath that returns 10-bit results.
- Shares the single engine between two host requesters and a built-in periodic auto-scan. The auto-scan alternates CH0/CH1 and keeps the latest sample per channel in registers.
- Sits between application logic and the engine, and adds a per-conversion timeout guard.

---
 rtl/mcp3002_pkg.sv | 18 +
 rtl/mcp3002_scan_timer.sv | 39 +++
 rtl/mcp3002_sched.sv | 142 ++++++++++++++
 tb/tb_mcp3002_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp3002_pkg.sv
// rtl/mcp3002_pkg.sv - shared types and constants for the MCP3002 conversion scheduler
package mcp3002_pkg;
  localparam int DATA_W   = 10;
  localparam int SGL_DIFF = 1;
  localparam int ODD_SIGN = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;
  typedef enum logic [1:0] {REQ0, REQ1, SCAN} owner_t;

  // Auto-scan conversions are always single-ended on the selected channel.
  function automatic logic [1:0] scan_cfg(input logic ch);
    logic [1:0] cfg;
    cfg = '0;
    cfg[SGL_DIFF] = 1'b1;
    cfg[ODD_SIGN] = ch;
    return cfg;
  endfunction
endpackage

// File: rtl/mcp3002_scan_timer.sv
// rtl/mcp3002_scan_timer.sv - auto-scan period counter with pending and sticky overrun flags
module mcp3002_scan_timer
  import mcp3002_pkg::*;
#(
  parameter int SCAN_PERIOD = 1200,
  parameter int CNT_W       = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr_pending,
  output logic pending,
  output logic overrun
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(SCAN_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      pending <= 1'b1;
      if (pending) overrun <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (clr_pending) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mcp3002_sched.sv
// rtl/mcp3002_sched.sv - shares one MCP3002 SPI engine between two hosts and a periodic auto-scan
module mcp3002_sched
  import mcp3002_pkg::*;
#(
  parameter int SCAN_PERIOD = 1200,
  parameter int TIMEOUT     = 4095,
  parameter int CNT_W       = 12
) (
  input  logic              _i_clk,
  input  logic              _i_rst,
  input  logic              _i_scan_en,
  input  logic              _i_req0_valid,
  input  logic [1:0]        _i_req0_cfg,
  output logic              _o_req0_ready,
  input  logic              _i_req1_valid,
  input  logic [1:0]        _i_req1_cfg,
  output logic              _o_req1_ready,
  output logic              _o_rsp_valid,
  output logic              _o_rsp_id,
  output logic [DATA_W-1:0] _o_rsp_data,
  output logic              _o_rsp_err,
  input  logic              _i_rsp_ready,
  output logic              _o_conv_start,
  output logic [1:0]        _o_conv_cfg,
  output logic              _o_conv_abort,
  input  logic              _i_conv_done,
  input  logic [DATA_W-1:0] _i_conv_data,
  output logic [DATA_W-1:0] _o_scan_ch0,
  output logic [DATA_W-1:0] _o_scan_ch1,
  output logic              _o_scan_strobe,
  output logic              _o_scan_overrun
);

  state_t           state;
  owner_t           owner;
  logic             last_req1;
  logic             scan_ch;
  logic [CNT_W-1:0] tcnt;
  logic             scan_pending;
  logic             can_grant, g_scan, g0, g1, timeout_hit;

  mcp3002_scan_timer #(
    .SCAN_PERIOD (SCAN_PERIOD),
    .CNT_W       (CNT_W)
  ) u_scan_timer (
    .clk         (_i_clk),
    .rst         (_i_rst),
    .en          (_i_scan_en),
    .clr_pending (g_scan),
    .pending     (scan_pending),
    .overrun     (_o_scan_overrun)
  );

  // Nothing is granted while a host response is still waiting to be consumed.
  assign can_grant = (state == IDLE) && !_o_rsp_valid && !_i_rst;
  assign g_scan    = can_grant && scan_pending;
  assign g0        = can_grant && !scan_pending && _i_req0_valid && (!_i_req1_valid || last_req1);
  assign g1        = can_grant && !scan_pending && _i_req1_valid && (!_i_req0_valid || !last_req1);

  assign _o_req0_ready = g0;
  assign _o_req1_ready = g1;

  // Abort is withheld when done lands on the final cycle: that conversion counts as good.
  assign timeout_hit   = (state == WAIT) && (tcnt == CNT_W'(TIMEOUT - 1)) && !_i_conv_done;
  assign _o_conv_abort = timeout_hit;

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state          <= IDLE;
      owner          <= REQ0;
      last_req1      <= 1'b1;
      scan_ch        <= 1'b0;
      tcnt           <= '0;
      _o_conv_start  <= 1'b0;
      _o_conv_cfg    <= '0;
      _o_rsp_valid   <= 1'b0;
      _o_rsp_id      <= 1'b0;
      _o_rsp_data    <= '0;
      _o_rsp_err     <= 1'b0;
      _o_scan_ch0    <= '0;
      _o_scan_ch1    <= '0;
      _o_scan_strobe <= 1'b0;
    end else begin
      _o_conv_start  <= 1'b0;
      _o_scan_strobe <= 1'b0;
      if (_o_rsp_valid && _i_rsp_ready) begin
        _o_rsp_valid <= 1'b0;
        _o_rsp_id    <= 1'b0;
        _o_rsp_data  <= '0;
        _o_rsp_err   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (g_scan) begin
            owner         <= SCAN;
            _o_conv_cfg   <= scan_cfg(scan_ch);
            _o_conv_start <= 1'b1;
            state         <= ISSUE;
          end else if (g0) begin
            owner         <= REQ0;
            last_req1     <= 1'b0;
            _o_conv_cfg   <= _i_req0_cfg;
            _o_conv_start <= 1'b1;
            state         <= ISSUE;
          end else if (g1) begin
            owner         <= REQ1;
            last_req1     <= 1'b1;
            _o_conv_cfg   <= _i_req1_cfg;
            _o_conv_start <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (_i_conv_done || timeout_hit) begin
            state <= COMPLETE;
            if (owner == SCAN) begin
              if (_i_conv_done) begin
                if (scan_ch) _o_scan_ch1 <= _i_conv_data;
                else         _o_scan_ch0 <= _i_conv_data;
                _o_scan_strobe <= 1'b1;
              end
              scan_ch <= ~scan_ch;
            end else begin
              _o_rsp_valid <= 1'b1;
              _o_rsp_id    <= (owner == REQ1);
              _o_rsp_data  <= _i_conv_done ? _i_conv_data : '0;
              _o_rsp_err   <= !_i_conv_done;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3002_sched.sv
// tb/tb_mcp3002_sched.sv - directed self-checking bench for mcp3002_sched
module tb_mcp3002_sched;

  localparam int W_R0 = 0, W_R1 = 1, W_RSP = 2, W_START = 3, W_ABORT = 4, W_STROBE = 5, W_ANY = 6;

  logic       clk, rst, scan_en;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_cfg, req1_cfg, conv_cfg;
  logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [9:0] rsp_data, conv_data, scan_ch0, scan_ch1;
  logic       conv_start, conv_abort, conv_done, scan_strobe, scan_overrun;

  int         checks = 0, failures = 0;
  int         n_start = 0, n_abort = 0, n_strobe = 0;
  int         eng_delay;
  logic [9:0] eng_data;

  mcp3002_sched #(.SCAN_PERIOD(200), .TIMEOUT(64), .CNT_W(12)) dut (
    ._i_clk          (clk),
    ._i_rst          (rst),
    ._i_scan_en      (scan_en),
    ._i_req0_valid   (req0_valid),
    ._i_req0_cfg     (req0_cfg),
    ._o_req0_ready   (req0_ready),
    ._i_req1_valid   (req1_valid),
    ._i_req1_cfg     (req1_cfg),
    ._o_req1_ready   (req1_ready),
    ._o_rsp_valid    (rsp_valid),
    ._o_rsp_id       (rsp_id),
    ._o_rsp_data     (rsp_data),
    ._o_rsp_err      (rsp_err),
    ._i_rsp_ready    (rsp_ready),
    ._o_conv_start   (conv_start),
    ._o_conv_cfg     (conv_cfg),
    ._o_conv_abort   (conv_abort),
    ._i_conv_done    (conv_done),
    ._i_conv_data    (conv_data),
    ._o_scan_ch0     (scan_ch0),
    ._o_scan_ch1     (scan_ch1),
    ._o_scan_strobe  (scan_strobe),
    ._o_scan_overrun (scan_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (conv_start)  n_start++;
    if (conv_abort)  n_abort++;
    if (scan_strobe) n_strobe++;
  end

  // Engine model: done (with eng_data) eng_delay cycles after start; eng_delay 0 never answers.
  initial begin
    conv_done = 1'b0;
    conv_data = '0;
    forever begin
      @(negedge clk);
      if (conv_start && eng_delay > 0) begin
        repeat (eng_delay) @(negedge clk);
        conv_done = 1'b1;
        conv_data = eng_data;
        @(negedge clk);
        conv_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      W_R0:     return req0_ready;
      W_R1:     return req1_ready;
      W_RSP:    return rsp_valid;
      W_START:  return conv_start;
      W_ABORT:  return conv_abort;
      W_STROBE: return scan_strobe;
      W_ANY:    return req0_ready | req1_ready;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, output int n);
    n = 0;
    while (!probe(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_rsp();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int         n, starts0, strobes0, bad;
    logic [1:0] exp_grant;
    logic       exp_id;

    rst = 1'b1; scan_en = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_cfg = '0; req1_valid = 1'b0; req1_cfg = '0;
    eng_delay = 0; eng_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rsp_valid, rsp_id, rsp_data, rsp_err, conv_start, conv_cfg, conv_abort,
                          scan_ch0, scan_ch1, scan_strobe, scan_overrun}, 64'h0);
    chk("reset_ready", {req0_ready, req1_ready}, 2'b00);

    // single req0 conversion and its latency
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b1; req0_cfg = 2'b10; eng_delay = 20; eng_data = 10'h2A5;
    @(negedge clk);
    chk("t1_grant", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    chk("t1_ready_one_cycle", req0_ready, 1'b0);
    chk("t1_start", conv_start, 1'b1);
    chk("t1_cfg", conv_cfg, 2'b10);
    req0_valid = 1'b0;
    wait_for(W_RSP, 100, n);
    chk("t1_rsp_latency", n, 21);
    chk("t1_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 1'b0, 1'b0, 10'h2A5});
    take_rsp();
    chk("t1_rsp_cleared", rsp_valid, 1'b0);

    // lone req1 granted back-to-back
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_cfg = 2'b11; eng_delay = 5; eng_data = 10'h155;
    wait_for(W_R1, 20, n);
    chk("t2_grant_a", req1_ready, 1'b1);
    @(negedge clk);
    chk("t2_cfg", conv_cfg, 2'b11);
    wait_for(W_RSP, 50, n);
    chk("t2_rsp_a", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 10'h155});
    take_rsp();
    chk("t2_b2b_grant", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0; eng_data = 10'h0AA;
    wait_for(W_RSP, 50, n);
    chk("t2_rsp_b", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 10'h0AA});
    take_rsp();

    // both requesters held: round-robin 0,1,0,1
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cfg = 2'b00; req1_valid = 1'b1; req1_cfg = 2'b01; eng_delay = 4;
    for (int i = 0; i < 4; i++) begin
      eng_data  = 10'h300 + 10'(i);
      exp_id    = (i % 2) == 1;
      exp_grant = exp_id ? 2'b01 : 2'b10;
      wait_for(W_ANY, 30, n);
      chk("t3_grant", {req0_ready, req1_ready}, exp_grant);
      @(posedge clk); #1;
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      chk("t3_cfg", conv_cfg, {1'b0, exp_id});
      wait_for(W_RSP, 50, n);
      chk("t3_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, exp_id, 10'h300 + 10'(i)});
      take_rsp();
    end

    // engine never answers: abort on WAIT cycle 64
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cfg = 2'b10; eng_delay = 0;
    @(negedge clk);
    chk("t4_grant", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("t4_start", conv_start, 1'b1);
    wait_for(W_ABORT, 100, n);
    chk("t4_abort_cycle", n, 64);
    @(negedge clk);
    chk("t4_abort_pulse", conv_abort, 1'b0);
    chk("t4_rsp_err", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 1'b0, 1'b1, 10'h000});
    take_rsp();
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_cfg = 2'b11; eng_delay = 10; eng_data = 10'h0F0;
    @(negedge clk);
    chk("t4_next_grant", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_for(W_RSP, 50, n);
    chk("t4_next_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 1'b1, 1'b0, 10'h0F0});
    take_rsp();
    chk("t4_abort_count", n_abort, 1);

    // auto-scan CH0 then CH1
    strobes0 = n_strobe;
    @(posedge clk); #1;
    scan_en = 1'b1; eng_delay = 20; eng_data = 10'h100;
    wait_for(W_START, 300, n);
    chk("t5_start_a", conv_start, 1'b1);
    chk("t5_cfg_a", conv_cfg, 2'b10);
    wait_for(W_STROBE, 50, n);
    chk("t5_strobe_a", scan_strobe, 1'b1);
    chk("t5_regs_a", {scan_ch0, scan_ch1}, {10'h100, 10'h000});
    eng_data = 10'h3FF;
    @(negedge clk);
    wait_for(W_START, 300, n);
    chk("t5_start_b", conv_start, 1'b1);
    chk("t5_cfg_b", conv_cfg, 2'b11);
    wait_for(W_STROBE, 50, n);
    chk("t5_regs_b", {scan_ch0, scan_ch1}, {10'h100, 10'h3FF});
    @(posedge clk); #1 scan_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_strobe_count", n_strobe - strobes0, 2);
    chk("t5_no_rsp", rsp_valid, 1'b0);
    chk("t5_no_overrun", scan_overrun, 1'b0);

    // response stalled past two scan periods: overrun, then a single scan
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    scan_en = 1'b1; req0_valid = 1'b1; req0_cfg = 2'b00; eng_delay = 5; eng_data = 10'h011;
    @(negedge clk);
    chk("t6_grant", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_for(W_RSP, 50, n);
    chk("t6_rsp", rsp_valid, 1'b1);
    starts0 = n_start;
    repeat (450) @(negedge clk);
    chk("t6_overrun", scan_overrun, 1'b1);
    chk("t6_rsp_held", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 1'b0, 1'b0, 10'h011});
    chk("t6_no_start_while_held", n_start - starts0, 0);
    eng_data = 10'h222;
    take_rsp();
    repeat (100) @(negedge clk);
    chk("t6_one_scan", n_start - starts0, 1);
    chk("t6_overrun_sticky", scan_overrun, 1'b1);
    chk("t6_scan_ch0", scan_ch0, 10'h222);
    @(posedge clk); #1 scan_en = 1'b0;

    // response held 50 cycles with req1 waiting
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cfg = 2'b01; eng_delay = 6; eng_data = 10'h1C3;
    @(negedge clk);
    chk("t7_grant0", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_for(W_RSP, 50, n);
    chk("t7_rsp", rsp_valid, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_cfg = 2'b10;
    starts0 = n_start;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 10'h1C3} || req1_ready) bad++;
    end
    chk("t7_stable_cycles_bad", bad, 0);
    chk("t7_no_start", n_start - starts0, 0);
    take_rsp();
    chk("t7_grant_after_accept", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0; eng_data = 10'h2E1;
    wait_for(W_RSP, 50, n);
    chk("t7_rsp1", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 1'b1, 1'b0, 10'h2E1});
    take_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
